// File: rtl/multicycle_controller_pkg.sv
// arm_ctrl_pkg: shared types and constants for the ARMv4 multicycle sequencer.
// Holds the state enum, ALUControl / ResultSrc / ALUSrcB encodings, the
// data-processing cmd codes, the condition-code values and a cmd-to-ALU helper.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Unknown cmd values fall back to ADD; CMP shares the SUB operation.
    function automatic logic [1:0] alu_ctrl_of(input logic [3:0] cmd);
        logic [1:0] ctl;
        case (cmd)
            CMD_ADD: ctl = ALU_ADD;
            CMD_SUB: ctl = ALU_SUB;
            CMD_CMP: ctl = ALU_SUB;
            CMD_AND: ctl = ALU_AND;
            CMD_ORR: ctl = ALU_ORR;
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: controller <-> datapath/memory bundle.
//   Instr[31:12], ALUFlags[3:0] {N,Z,C,V}, mem_ready  : datapath -> controller
//   PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc, ImmSrc, ALUSrcA,
//   ALUSrcB, ResultSrc, ALUControl                    : controller -> datapath
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         mem_ready;
    logic         PCWrite;
    logic         RegWrite;
    logic         MemWrite;
    logic         IRWrite;
    logic         AdrSrc;
    logic [1:0]   RegSrc;
    logic [1:0]   ImmSrc;
    logic         ALUSrcA;
    logic [1:0]   ALUSrcB;
    logic [1:0]   ResultSrc;
    logic [1:0]   ALUControl;

    modport master (
        input  Instr, ALUFlags, mem_ready,
        output PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUControl
    );

    modport slave (
        output Instr, ALUFlags, mem_ready,
        input  PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUControl
    );
endinterface

// File: rtl/multicycle_controller_cond_check.sv
// cond_check: combinational ARM condition evaluation.
//   cond[3:0]  : instruction condition field
//   flags[3:0] : {N,Z,C,V} from the flag register
//   cond_ex    : 1 when the instruction is allowed to write state
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);
    logic n_s, z_s, c_s, v_s;
    assign {n_s, z_s, c_s, v_s} = flags;

    // Full ARM condition table; NV never executes.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z_s;
            COND_NE: cond_ex = ~z_s;
            COND_CS: cond_ex = c_s;
            COND_CC: cond_ex = ~c_s;
            COND_MI: cond_ex = n_s;
            COND_PL: cond_ex = ~n_s;
            COND_VS: cond_ex = v_s;
            COND_VC: cond_ex = ~v_s;
            COND_HI: cond_ex = c_s & ~z_s;
            COND_LS: cond_ex = ~c_s | z_s;
            COND_GE: cond_ex = (n_s == v_s);
            COND_LT: cond_ex = (n_s != v_s);
            COND_GT: cond_ex = ~z_s & (n_s == v_s);
            COND_LE: cond_ex = z_s | (n_s != v_s);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: registered sequencer for the multicycle ARMv4 core.
//   clk, rst : clock and synchronous active-high reset
//   bus      : multicycle_controller_if.master (instruction/flags/mem_ready in,
//              every datapath enable and mux select out)
// Holds the state register, the NZCV flag register and the latched condition
// outcome; outputs are decoded from registered state (IRWrite/PCWrite in FETCH
// additionally follow mem_ready). All outputs are forced to 0 while rst is high.
module multicycle_controller
    import arm_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);
    state_t     state_r;
    logic [3:0] flags_r;
    logic       cond_ex_r;
    logic       cond_ex_s;

    logic [1:0] op_s;
    logic [3:0] cmd_s;
    logic       ibit_s, sbit_s, ubit_s, is_cmp_s, rd15_s, cv_upd_s;
    logic [1:0] dp_alu_s;

    assign op_s     = bus.Instr[27:26];
    assign cmd_s    = bus.Instr[24:21];
    assign ibit_s   = bus.Instr[25];
    assign ubit_s   = bus.Instr[23];
    assign sbit_s   = bus.Instr[20];      // also the L bit for memory ops
    assign is_cmp_s = (cmd_s == CMD_CMP);
    assign rd15_s   = (bus.Instr[15:12] == 4'd15);
    assign dp_alu_s = alu_ctrl_of(cmd_s);
    // Logical ops leave C and V untouched.
    assign cv_upd_s = (dp_alu_s == ALU_ADD) || (dp_alu_s == ALU_SUB);

    cond_check u_cond (
        .cond    (bus.Instr[31:28]),
        .flags   (flags_r),
        .cond_ex (cond_ex_s)
    );

    // State, flag register and latched condition outcome.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_FETCH;
            flags_r   <= 4'b0000;
            cond_ex_r <= 1'b0;
        end else begin
            case (state_r)
                S_FETCH:  if (bus.mem_ready) state_r <= S_DECODE;
                S_DECODE: begin
                    cond_ex_r <= cond_ex_s;
                    case (op_s)
                        OP_DP:   state_r <= ibit_s ? S_EXECUTEI : S_EXECUTER;
                        OP_MEM:  state_r <= S_MEMADR;
                        OP_BR:   state_r <= S_BRANCH;
                        default: state_r <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state_r <= sbit_s ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (bus.mem_ready) state_r <= S_MEMWB;
                S_MEMWB:    state_r <= S_FETCH;
                // A suppressed store does not wait for memory.
                S_MEMWRITE: if (bus.mem_ready || !cond_ex_r) state_r <= S_FETCH;
                S_EXECUTER, S_EXECUTEI: begin
                    state_r <= S_ALUWB;
                    if (cond_ex_r && (sbit_s || is_cmp_s)) begin
                        flags_r[3:2] <= bus.ALUFlags[3:2];
                        if (cv_upd_s) flags_r[1:0] <= bus.ALUFlags[1:0];
                    end
                end
                S_ALUWB:  state_r <= S_FETCH;
                S_BRANCH: state_r <= S_FETCH;
                default:  state_r <= S_FETCH;
            endcase
        end
    end

    logic       pcw_s, rw_s, mw_s, irw_s, adr_s, srca_s;
    logic [1:0] regsrc_s, imm_s, srcb_s, res_s, alu_s;

    // Moore output decode; everything defaults to 0 and reset forces all 0.
    always_comb begin
        pcw_s    = 1'b0;
        rw_s     = 1'b0;
        mw_s     = 1'b0;
        irw_s    = 1'b0;
        adr_s    = 1'b0;
        srca_s   = 1'b0;
        regsrc_s = 2'b00;
        imm_s    = 2'b00;
        srcb_s   = SRCB_REG;
        res_s    = RES_ALUOUT;
        alu_s    = ALU_ADD;
        if (rst) begin
            imm_s = 2'b00;
        end else begin
            imm_s = op_s;
            case (state_r)
                S_FETCH: begin
                    srca_s = 1'b1;
                    srcb_s = SRCB_FOUR;
                    res_s  = RES_ALU;
                    irw_s  = bus.mem_ready;
                    pcw_s  = bus.mem_ready;
                end
                S_DECODE: begin
                    srca_s = 1'b1;
                    srcb_s = SRCB_FOUR;
                    res_s  = RES_ALU;
                end
                S_MEMADR: begin
                    srcb_s = SRCB_IMM;
                    alu_s  = ubit_s ? ALU_ADD : ALU_SUB;
                end
                S_MEMREAD: adr_s = 1'b1;
                S_MEMWB: begin
                    res_s = RES_DATA;
                    rw_s  = cond_ex_r;
                end
                S_MEMWRITE: begin
                    adr_s    = 1'b1;
                    regsrc_s = 2'b10;
                    mw_s     = cond_ex_r;
                end
                S_EXECUTER: alu_s = dp_alu_s;
                S_EXECUTEI: begin
                    srcb_s = SRCB_IMM;
                    alu_s  = dp_alu_s;
                end
                S_ALUWB: begin
                    rw_s  = cond_ex_r & ~is_cmp_s & ~rd15_s;
                    pcw_s = cond_ex_r & ~is_cmp_s & rd15_s;
                end
                S_BRANCH: begin
                    regsrc_s = 2'b01;
                    srcb_s   = SRCB_IMM;
                    res_s    = RES_ALU;
                    pcw_s    = cond_ex_r;
                end
                default: ;
            endcase
        end
    end

    assign bus.PCWrite    = pcw_s;
    assign bus.RegWrite   = rw_s;
    assign bus.MemWrite   = mw_s;
    assign bus.IRWrite    = irw_s;
    assign bus.AdrSrc     = adr_s;
    assign bus.RegSrc     = regsrc_s;
    assign bus.ImmSrc     = imm_s;
    assign bus.ALUSrcA    = srca_s;
    assign bus.ALUSrcB    = srcb_s;
    assign bus.ResultSrc  = res_s;
    assign bus.ALUControl = alu_s;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: the driver builds each instruction's expected per-cycle
// control word from a behavioural model and queues it; a monitor on the
// falling edge pops and compares against the DUT outputs.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_controller_if bus();
    multicycle_controller dut (.clk(clk), .rst(rst), .bus(bus));

    localparam int T_RST = 0, T_FETCH = 1, T_DEC = 2, T_EXE = 3, T_ALUWB = 4,
                   T_MADR = 5, T_MRD = 6, T_MWB = 7, T_MWR = 8, T_BR = 9;

    logic [15:0] exp_q[$];
    int          tag_q[$];
    int          total = 0;
    int          bad = 0;
    logic [3:0]  mflags = 4'b0000;   // model NZCV
    logic [1:0]  cur_imm = 2'b00;

    function automatic string tname(input int t);
        case (t)
            T_RST: return "reset";     T_FETCH: return "fetch";
            T_DEC: return "decode";    T_EXE: return "execute";
            T_ALUWB: return "aluwb";   T_MADR: return "memadr";
            T_MRD: return "memread";   T_MWB: return "memwb";
            T_MWR: return "memwrite";  T_BR: return "branch";
            default: return "unknown";
        endcase
    endfunction

    // Control word: {PCW,RW,MW,IRW,Adr,RegSrc,ImmSrc,SrcA,SrcB,Res,ALU}
    function automatic logic [15:0] w(input logic pcw, rw, mw, irw, adr,
                                      input logic [1:0] rs, input logic sa,
                                      input logic [1:0] sb, res, alu);
        return {pcw, rw, mw, irw, adr, rs, cur_imm, sa, sb, res, alu};
    endfunction

    // Condition model: cond[3:1] picks a base test, cond[0] inverts it.
    function automatic bit cond_pass(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        if (cond == 4'd15) return 1'b0;
        if (cond == 4'd14) return 1'b1;
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & !z;
            3'd5: base = (n == v);
            default: base = !z & (n == v);
        endcase
        return base ^ cond[0];
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 2'd0;
            4'b0010: return 2'd1;
            4'b1010: return 2'd1;
            4'b0000: return 2'd2;
            4'b1100: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic step(input logic r, input logic mr, input logic [3:0] f,
                        input logic [31:12] ins, input logic [15:0] e, input int t);
        @(posedge clk);
        #1;
        rst = r;
        bus.mem_ready = mr;
        bus.ALUFlags = f;
        bus.Instr = ins;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    // Build the expected cycle sequence of one instruction and drive it.
    // abort_tag >= 0: replace the first cycle with that tag by rst_len reset cycles.
    task automatic run_instr(input logic [31:12] ins, input int wf, input int wm,
                             input bit xf_rand, input logic [3:0] xf,
                             input int abort_tag, input int rst_len);
        logic [15:0] ea[$];
        bit          ma[$];
        int          ta[$];
        int          xi;
        bit          c, cmp, rd15;
        logic [1:0]  op, ac;
        logic [3:0]  cmd, f, drv;
        logic [31:0] rnd;
        op = ins[27:26]; cmd = ins[24:21]; cur_imm = op;
        cmp = (cmd == 4'b1010); rd15 = (ins[15:12] == 4'hF); ac = alu_of(cmd);
        c = cond_pass(ins[31:28], mflags);
        xi = -1; drv = 4'b0000;
        for (int i = 0; i < wf; i++) begin
            ea.push_back(w(0,0,0,0,0,2'd0,1,2'd2,2'd2,2'd0)); ma.push_back(0); ta.push_back(T_FETCH);
        end
        ea.push_back(w(1,0,0,1,0,2'd0,1,2'd2,2'd2,2'd0)); ma.push_back(1); ta.push_back(T_FETCH);
        rnd = $urandom;
        ea.push_back(w(0,0,0,0,0,2'd0,1,2'd2,2'd2,2'd0)); ma.push_back(rnd[0]); ta.push_back(T_DEC);
        if (op == 2'd0) begin
            xi = ea.size();
            ea.push_back(w(0,0,0,0,0,2'd0,0,{1'b0, ins[25]},2'd0,ac)); ma.push_back(rnd[1]); ta.push_back(T_EXE);
            ea.push_back(w(c & !cmp & rd15, c & !cmp & !rd15,0,0,0,2'd0,0,2'd0,2'd0,2'd0));
            ma.push_back(rnd[2]); ta.push_back(T_ALUWB);
        end else if (op == 2'd1) begin
            ea.push_back(w(0,0,0,0,0,2'd0,0,2'd1,2'd0,ins[23] ? 2'd0 : 2'd1)); ma.push_back(rnd[1]); ta.push_back(T_MADR);
            if (ins[20]) begin
                for (int i = 0; i <= wm; i++) begin
                    ea.push_back(w(0,0,0,0,1,2'd0,0,2'd0,2'd0,2'd0)); ma.push_back(i == wm); ta.push_back(T_MRD);
                end
                ea.push_back(w(0,c,0,0,0,2'd0,0,2'd0,2'd1,2'd0)); ma.push_back(rnd[2]); ta.push_back(T_MWB);
            end else if (c) begin
                for (int i = 0; i <= wm; i++) begin
                    ea.push_back(w(0,0,1,0,1,2'd2,0,2'd0,2'd0,2'd0)); ma.push_back(i == wm); ta.push_back(T_MWR);
                end
            end else begin
                ea.push_back(w(0,0,0,0,1,2'd2,0,2'd0,2'd0,2'd0)); ma.push_back(0); ta.push_back(T_MWR);
            end
        end else if (op == 2'd2) begin
            ea.push_back(w(c,0,0,0,0,2'd1,0,2'd1,2'd2,2'd0)); ma.push_back(rnd[1]); ta.push_back(T_BR);
        end
        for (int k = 0; k < ea.size(); k++) begin
            rnd = $urandom;
            if (ta[k] == abort_tag) begin
                for (int r = 0; r < rst_len; r++) step(1, ma[k], rnd[7:4], ins, 16'h0000, T_RST);
                mflags = 4'b0000;
                return;
            end
            f = (k == xi && !xf_rand) ? xf : rnd[3:0];
            if (k == xi) drv = f;
            step(0, ma[k], f, ins, ea[k], ta[k]);
        end
        if (xi >= 0 && c && (ins[20] || cmp)) begin
            mflags[3:2] = drv[3:2];
            if (ac == 2'd0 || ac == 2'd1) mflags[1:0] = drv[1:0];
        end
    endtask

    // Monitor: compare one queued control word per cycle, away from the edge.
    always @(negedge clk) begin
        logic [15:0] e, a;
        int t;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.IRWrite, bus.AdrSrc,
                 bus.RegSrc, bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                 bus.ALUControl};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s at %0t: got=%04h want=%04h", tname(t), $time, a, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r1, r2;
        int at;
        bus.Instr = 20'h00000; bus.ALUFlags = 4'h0; bus.mem_ready = 1'b0;
        step(1, 0, 4'h0, 20'h00000, 16'h0000, T_RST);
        step(1, 1, 4'hF, 20'h00000, 16'h0000, T_RST);
        mflags = 4'b0000;
        // ADD R1,R2,#5
        run_instr(20'hE2821, 0, 0, 1, 4'h0, -1, 0);
        // CMP equal -> BEQ taken, CMP unequal -> BEQ not taken
        run_instr(20'hE1510, 0, 0, 0, 4'b0110, -1, 0);
        run_instr(20'h0A000, 0, 0, 1, 4'h0, -1, 0);
        run_instr(20'hE1510, 1, 0, 0, 4'b1000, -1, 0);
        run_instr(20'h0A000, 0, 0, 1, 4'h0, -1, 0);
        // LDR with 3 wait cycles in MEMREAD
        run_instr(20'hE5910, 0, 3, 1, 4'h0, -1, 0);
        // STRNE with Z=1: suppressed, single MEMWRITE cycle
        run_instr(20'hE1510, 0, 0, 0, 4'b0100, -1, 0);
        run_instr(20'h15810, 0, 2, 1, 4'h0, -1, 0);
        // Reset held 2 cycles mid-LDR, then a zero-wait fetch
        run_instr(20'hE5910, 0, 3, 1, 4'h0, T_MRD, 2);
        run_instr(20'hE2821, 0, 0, 1, 4'h0, -1, 0);
        // Reset during MEMWRITE with mem_ready low
        run_instr(20'hE5810, 1, 2, 1, 4'h0, T_MWR, 1);
        run_instr(20'hF2821, 0, 0, 1, 4'h0, -1, 0);   // NV data-processing
        run_instr(20'hEC000, 0, 0, 1, 4'h0, -1, 0);   // op 11
        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            r1 = $urandom; r2 = $urandom;
            if (r2[3:0] < 4'd5) r1[31:28] = 4'hE;
            if (r2[7:4] < 4'd3) r1[15:12] = 4'hF;
            at = (r2[12:8] == 5'd0) ? int'(r2[16:13] % 4'd10) : -1;
            run_instr(r1[31:12], int'(r2[18:17]) % 3, int'(r2[20:19]) % 3, 1, 4'h0,
                      at, 1 + int'(r2[21]));
        end
        for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(posedge clk);
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle sequencer for the ARMv4 core. It replaces the single-cycle decode and condition path with a registered state machine, so one ALU and one unified instruction/data memory are shared across the cycles of each instruction. It decodes the upper instruction field, latches the condition outcome, owns the NZCV flag register and drives every datapath enable and mux select. A `mem_ready` handshake stretches memory cycles.

## Interface
Parameters: none.

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `Instr`  in  [31:12]  current instruction register bits
- `ALUFlags`  in  4  {N,Z,C,V} from the ALU this cycle
- `mem_ready`  in  1  memory access completes this cycle
- `PCWrite`  out  1  PC register load enable
- `RegWrite`  out  1  register file write enable
- `MemWrite`  out  1  data memory write enable
- `IRWrite`  out  1  instruction register load enable
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut register
- `RegSrc`  out  2  bit 0 selects R15 as RA1 (branch); bit 1 selects Rd as RA2 (STR)
- `ImmSrc`  out  2  extender mode, equal to `Instr[27:26]`
- `ALUSrcA`  out  1  ALU input A: 0 = RegA, 1 = PC
- `ALUSrcB`  out  2  ALU input B: 00 = RegB, 01 = ExtImm, 10 = constant 4
- `ResultSrc`  out  2  result select: 00 = ALUOut register, 01 = Data register, 10 = ALU result direct
- `ALUControl`  out  2  ALU operation: 00 = ADD, 01 = SUB, 10 = AND, 11 = ORR

## Operation
- **Field decode**
  - op = `Instr[27:26]`; funct = `Instr[25:20]`; Rd = `Instr[15:12]`.
  - DP cmd = `Instr[24:21]`: ADD 0100, SUB 0010, AND 0000, ORR 1100, CMP 1010 (CMP executes as SUB).
  - Any other cmd is treated as ADD.
- **States** (only changes listed; in every state unlisted enables are 0 and unlisted selects are 0):
  - FETCH
    - AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
    - IRWrite=PCWrite=`mem_ready`.
    - Stays in FETCH until `mem_ready`, then → DECODE.
  - DECODE
    - ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
    - Latches `cond_ex_q` = condition check of `Instr[31:28]` against the flag register.
    - op 00 → EXECUTER or EXECUTEI (by I bit = `Instr[25]`); op 01 → MEMADR; op 10 → BRANCH; op 11 → FETCH with no writes.
  - MEMADR
    - ALUSrcB=01; ADD if U (`Instr[23]`) = 1, else SUB.
    - L (`Instr[20]`) = 1 → MEMREAD, else → MEMWRITE.
  - MEMREAD: AdrSrc=1; waits for `mem_ready`, then → MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=`cond_ex_q`; → FETCH.
  - MEMWRITE
    - AdrSrc=1, RegSrc[1]=1, MemWrite=`cond_ex_q`.
    - Exits to FETCH when `mem_ready` or when `cond_ex_q`=0.
  - EXECUTER / EXECUTEI: ALUSrcB=00 or 01 respectively; ALUControl from cmd; → ALUWB.
  - ALUWB
    - ResultSrc=00.
    - RegWrite = `cond_ex_q` & not CMP & Rd≠15.
    - PCWrite = `cond_ex_q` & not CMP & Rd=15.
    - → FETCH.
  - BRANCH
    - RegSrc[0]=1, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=`cond_ex_q`.
    - Link (BL) is not supported and executes as B.
    - → FETCH.
- **Flags**
  - Written only at the end of EXECUTER/EXECUTEI, and only when `cond_ex_q`=1 and (S=`Instr[20]` or CMP).
  - NZ update on every such write; CV update only for ADD, SUB and CMP.
- **Condition codes**
  - Full ARM set EQ through LE; 1110 = always.
  - 1111 = never: the instruction completes its states with all writes suppressed.

## Timing
- **Reset**
  - While `rst`=1, every enable output is 0 and selects are 0.
  - The edge with `rst` high sets state=FETCH, flags=0000, `cond_ex_q`=0.
  - A reset mid-instruction aborts it; no partial write occurs after the reset edge.
- **Latency with zero-wait memory:** DP 4 cycles, LDR 5, STR 4, B 3, op 11 2 cycles.
- **Memory wait states:** each low `mem_ready` cycle in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs stay constant during the wait.
- **Enable timing**
  - Enables are Moore outputs from the state register and the latched `cond_ex_q`.
  - IRWrite and PCWrite in FETCH also depend combinationally on `mem_ready`.
- **Flag timing:** flags change only on the EXECUTE→ALUWB edge. They are visible to the DECODE of the next instruction.

## Structure
- **Package `arm_ctrl_pkg`** holds:
  - the state enum;
  - ALUControl encodings;
  - ResultSrc and ALUSrcB constants;
  - DP cmd codes;
  - condition-code constants.
- **Sub-module `cond_check`**: combinational; inputs cond[3:0] and flags[3:0]; output cond_ex.
- **Top-level contents:** state register, flag register, `cond_ex_q`, next-state logic and output decode.

## Test plan
- **Reset:** hold `rst` 2 cycles mid-LDR → all enables 0, state FETCH, flags 0000. First post-reset cycle with `mem_ready`=1 → IRWrite=PCWrite=1.
- **ADD R1,R2,#5:** `Instr`=0xE2821, zero-wait → 4 cycles. Cycle 3 has ALUSrcB=01, ALUControl=00. RegWrite=1 only in cycle 4.
- **CMP then BEQ:** `Instr`=0xE1510 with equal operands → Z=1 after execute. Next `Instr`=0x0A000 → PCWrite=1 in its cycle 3. Repeating with Z=0 → PCWrite stays 0.
- **LDR R0,[R1,#4]:** `Instr`=0xE5910 with `mem_ready` low 3 cycles in MEMREAD → 8 cycles total. AdrSrc=1 throughout MEMREAD; RegWrite=1 with ResultSrc=01 in MEMWB.
- **Failed STR:** STRNE with Z=1 (`Instr`=0x15810) → MemWrite never asserted; MEMWRITE lasts 1 cycle even with `mem_ready`=0.
- **Reset during MEMWRITE:** `rst`=1 in MEMWRITE with `mem_ready`=0 → MemWrite=0 that cycle; FETCH on the next cycle.
